// File: rtl/cordic_rr_scheduler_pkg.sv
// cordic_rr_scheduler_pkg: shared constants and sizing helpers for the CORDIC scheduler
package cordic_rr_scheduler_pkg;
  localparam logic [31:0] ANG_0  = 32'h0000_0000;
  localparam logic [31:0] ANG_45 = 32'h2000_0000;
  localparam logic [31:0] ANG_60 = 32'h2AAA_AAAA;
  localparam logic [31:0] ANG_75 = 32'h3555_5555;
  localparam logic [31:0] ANG_90 = 32'h4000_0000;
  localparam int X_INIT = 19429;
  localparam int AMPLITUDE = 32000;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// cordic_rr_scheduler_if: requester, core and response signals of the CORDIC scheduler
interface cordic_rr_scheduler_if #(
  parameter int N_REQ    = 2,
  parameter int WIDTH    = 16,
  parameter int ANGLE_W  = 32,
  parameter int PIPE_LAT = 16
);
  localparam int IW = $clog2(PIPE_LAT + 2);
  logic                     en;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*ANGLE_W-1:0] req_angle;
  logic [N_REQ-1:0]         req_ready;
  logic [WIDTH-1:0]         cordic_x_in;
  logic [WIDTH-1:0]         cordic_y_in;
  logic [ANGLE_W-1:0]       cordic_angle;
  logic [WIDTH-1:0]         cordic_cos;
  logic [WIDTH-1:0]         cordic_sin;
  logic [N_REQ-1:0]         rsp_valid;
  logic [WIDTH-1:0]         rsp_cos;
  logic [WIDTH-1:0]         rsp_sin;
  logic [IW-1:0]            inflight;
  logic                     idle;
  modport master (
    input  en, req_valid, req_angle, cordic_cos, cordic_sin,
    output req_ready, cordic_x_in, cordic_y_in, cordic_angle, rsp_valid, rsp_cos, rsp_sin, inflight, idle
  );
  modport slave (
    output en, req_valid, req_angle, cordic_cos, cordic_sin,
    input  req_ready, cordic_x_in, cordic_y_in, cordic_angle, rsp_valid, rsp_cos, rsp_sin, inflight, idle
  );
endinterface

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searching upward from a rotating pointer
module rr_arbiter
  import cordic_rr_scheduler_pkg::*;
#(
  parameter int N = 2,
  localparam int TW = tag_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [TW-1:0] gnt_idx,
  output logic          gnt_any
);
  logic [TW-1:0] ptr_q, ptr_d;
  logic          hit;
  always_comb begin
    hit = 1'b0;
    gnt_idx = '0;
    // walk from farthest to nearest so the candidate closest to the pointer wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N]) begin
        hit = 1'b1;
        gnt_idx = TW'((int'(ptr_q) + k) % N);
      end
    end
    gnt_any = hit & en & rst_n;
    gnt = gnt_any ? N'(1) << gnt_idx : '0;
    ptr_d = gnt_any ? (gnt_idx == TW'(N - 1) ? '0 : gnt_idx + TW'(1)) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler: shares one pipelined CORDIC core among requesters, routing results by tag
module cordic_rr_scheduler
  import cordic_rr_scheduler_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int WIDTH    = 16,
  parameter int ANGLE_W  = 32,
  parameter int PIPE_LAT = 16,
  parameter int X_INIT   = cordic_rr_scheduler_pkg::X_INIT
) (
  input logic clk,
  input logic rst_n,
  cordic_rr_scheduler_if.master bus
);
  localparam int TW = tag_w(N_REQ);
  localparam int IW = $clog2(PIPE_LAT + 2);
  logic [N_REQ-1:0]               gnt;
  logic [TW-1:0]                  gnt_idx;
  logic                           gnt_any;
  logic [ANGLE_W-1:0]             angle_q, angle_d;
  logic [PIPE_LAT:0]              dl_valid_q, dl_valid_d;
  logic [PIPE_LAT:0][TW-1:0]      dl_tag_q, dl_tag_d;
  logic [N_REQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]               rsp_cos_q, rsp_cos_d, rsp_sin_q, rsp_sin_d;
  logic [IW-1:0]                  inflight_q, inflight_d;
  logic                           tail_valid;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.en),
    .req     (bus.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );
  // the tail stage lines up with the cycle the core presents that operation's result
  assign tail_valid = dl_valid_q[PIPE_LAT];
  always_comb begin
    angle_d = gnt_any ? bus.req_angle[gnt_idx*ANGLE_W +: ANGLE_W] : angle_q;
    dl_valid_d = {dl_valid_q[PIPE_LAT-1:0], gnt_any};
    dl_tag_d = {dl_tag_q[PIPE_LAT-1:0], gnt_idx};
    rsp_valid_d = tail_valid ? N_REQ'(1) << dl_tag_q[PIPE_LAT] : '0;
    rsp_cos_d = tail_valid ? bus.cordic_cos : rsp_cos_q;
    rsp_sin_d = tail_valid ? bus.cordic_sin : rsp_sin_q;
    inflight_d = inflight_q + IW'(gnt_any) - IW'(tail_valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q <= '0;
      dl_valid_q <= '0;
      dl_tag_q <= '0;
      rsp_valid_q <= '0;
      rsp_cos_q <= '0;
      rsp_sin_q <= '0;
      inflight_q <= '0;
    end else begin
      angle_q <= angle_d;
      dl_valid_q <= dl_valid_d;
      dl_tag_q <= dl_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cos_q <= rsp_cos_d;
      rsp_sin_q <= rsp_sin_d;
      inflight_q <= inflight_d;
    end
  end
  assign bus.req_ready    = gnt;
  assign bus.cordic_x_in  = WIDTH'(X_INIT);
  assign bus.cordic_y_in  = '0;
  assign bus.cordic_angle = angle_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_cos      = rsp_cos_q;
  assign bus.rsp_sin      = rsp_sin_q;
  assign bus.inflight     = inflight_q;
  assign bus.idle         = inflight_q == '0 && !gnt_any;
endmodule
